frame_scanner: RTL and testbench
================================

Name: frame_scanner

Overview:
- Read side of the 2-bit palette framebuffer. The sprite painter fills the back buffer; this block scans the front buffer and produces the panel video stream.
- Generates raster timing at clk_33m and issues one read per active pixel.
- Aligns returned palette data with the sync signals and maps palette to RGB.
- Owns front/back buffer selection through a swap handshake that is applied only at vertical blank.

Parameters:
COOR_WIDTH, 12, width of read_x/read_y and of the internal counters
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 48, hsync width (clocks)
H_BP, 88, horizontal back porch (clocks); H_TOTAL = 976
V_ACTIVE, 480, visible lines
V_FP, 13, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 32, vertical back porch (lines); V_TOTAL = 528
READ_LATENCY, 2, fixed framebuffer read latency (cycles), range 1..4

Ports:
clk_33m  input  1  pixel clock
rst_n  input  1  asynchronous reset, active-low
read_en  output  1  framebuffer read strobe, high for active pixels
read_x  output  COOR_WIDTH  pixel column to read
read_y  output  COOR_WIDTH  pixel row to read
read_buf  output  1  front buffer index being scanned
read_palette  input  2  palette returned READ_LATENCY cycles after read_en
swap_req  input  1  one-cycle pulse from painter: back buffer complete
swap_ack  output  1  one-cycle pulse: buffers swapped
frame_start  output  1  one-cycle pulse at start of vertical blank (painter restart)
video_hsync  output  1  active-low hsync
video_vsync  output  1  active-low vsync
video_de  output  1  data enable
video_red  output  8  red
video_green  output  8  green
video_blue  output  8  blue

Behaviour:
- Reset (rst_n low, async):
  - h_cnt = v_cnt = 0.
  - read_en = 0, read_x = read_y = 0, read_buf = 0.
  - swap_ack = 0, frame_start = 0, swap pending flag = 0.
  - video_hsync = video_vsync = 1, video_de = 0, RGB = 0.
  - Delay-line contents cleared.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps from V_TOTAL-1 to 0.
- Raster regions:
  - Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
- Reads:
  - Combinational from counters: read_en = active, read_x = h_cnt, read_y = v_cnt.
  - When not active, read_x/read_y hold 0.
- Output alignment:
  - hsync, vsync, de and the read_en tag pass through a READ_LATENCY-deep shift register.
  - Outputs are then registered once, so all video_* lag the counters by exactly READ_LATENCY+1 cycles.
- Palette map (registered; applied only when the delayed de is high, otherwise RGB = 0):
  - 0 -> FFFFFF
  - 1 -> ACACAC
  - 2 -> 535353
  - 3 -> 000000
- frame_start: high for one cycle when h_cnt == 0 and v_cnt == V_ACTIVE.
- Swap handshake:
  - A swap_req pulse sets pending.
  - At the frame_start cycle, if pending or swap_req is high: read_buf toggles, swap_ack pulses in the same cycle, pending clears.
  - Further swap_req while pending is already set has no additional effect (no double toggle).
  - swap_req in the frame_start cycle is honoured immediately.
  - read_buf never changes outside that cycle, so there is no tearing.
- Reset mid-frame: everything returns to reset values immediately. After release, the first frame starts at h_cnt = v_cnt = 0 and any pending swap is lost.

Optional Feature:
- Macro: FRAME_SCANNER_SCALE2_EN.
- When defined (2x pixel doubling, 400x240 logical framebuffer):
  - read_x = h_cnt >> 1, read_y = v_cnt >> 1.
  - read_en is still asserted every active cycle.
  - Timing, latency and syncs are unchanged.
- When undefined: 1:1 mapping as above.

Test Plan:
- Reset release, free run 2 frames -> hsync period 976 clocks, low 48 clocks; vsync period 515328 clocks, low 3 lines; 384000 video_de cycles per frame.
- read_palette = read_x[1:0] via a 2-cycle latency model -> pixel x=0 white, x=1 ACACAC, x=2 535353, x=3 000000; video_de rises exactly 3 cycles after the first read_en.
- swap_req pulsed at v_cnt=100 -> read_buf toggles and swap_ack pulses only at the frame_start cycle of that frame (h=0, v=480); frame_start pulses once per frame.
- swap_req twice within one frame, then once exactly in the frame_start cycle of the next frame -> exactly one toggle each frame, no lost or duplicate swap.
- rst_n low at h=500, v=200 for 3 cycles -> outputs immediately at reset values; first hsync after release at h_cnt = 840.
- FRAME_SCANNER_SCALE2_EN defined -> read_x sequence 0,0,1,1,…; read_y equals 120 on lines 240 and 241.

Source files
------------

// File: rtl/frame_scanner.sv
// frame_scanner: raster timing generator and read side of the 2-bit palette
// framebuffer. It issues one read per active pixel, delays the sync/de bits to
// line up with the returned palette data, maps the palette to RGB, and swaps the
// front/back buffers only at the start of vertical blank.
// Optional build macro: FRAME_SCANNER_SCALE2_EN (2x pixel doubling of the read
// coordinates; timing is unchanged).
module frame_scanner #(
  parameter int COOR_WIDTH   = 12,
  parameter int H_ACTIVE     = 800,
  parameter int H_FP         = 40,
  parameter int H_SYNC       = 48,
  parameter int H_BP         = 88,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 13,
  parameter int V_SYNC       = 3,
  parameter int V_BP         = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_33m,
  input  logic                  rst_n,
  output logic                  read_en,
  output logic [COOR_WIDTH-1:0] read_x,
  output logic [COOR_WIDTH-1:0] read_y,
  output logic                  read_buf,
  input  logic [1:0]            read_palette,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  frame_start,
  output logic                  video_hsync,
  output logic                  video_vsync,
  output logic                  video_de,
  output logic [7:0]            video_red,
  output logic [7:0]            video_green,
  output logic [7:0]            video_blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COOR_WIDTH-1:0] H_LAST = COOR_WIDTH'(H_TOTAL - 1);
  localparam logic [COOR_WIDTH-1:0] V_LAST = COOR_WIDTH'(V_TOTAL - 1);
  localparam logic [COOR_WIDTH-1:0] H_ACT  = COOR_WIDTH'(H_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] V_ACT  = COOR_WIDTH'(V_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] HS_BEG = COOR_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COOR_WIDTH-1:0] HS_END = COOR_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COOR_WIDTH-1:0] VS_BEG = COOR_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COOR_WIDTH-1:0] VS_END = COOR_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  logic [COOR_WIDTH-1:0]   h_cnt_q, h_cnt_d;
  logic [COOR_WIDTH-1:0]   v_cnt_q, v_cnt_d;
  logic                    read_buf_q, read_buf_d;
  logic                    pending_q, pending_d;
  // de doubles as the read_en tag: a pixel is read exactly when it is displayed
  logic [READ_LATENCY-1:0] de_pipe_q, de_pipe_d;
  logic [READ_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
  logic [READ_LATENCY-1:0] vs_pipe_q, vs_pipe_d;
  logic                    video_hsync_q, video_hsync_d;
  logic                    video_vsync_q, video_vsync_d;
  logic                    video_de_q, video_de_d;
  logic [23:0]             video_rgb_q, video_rgb_d;

  logic active;
  logic hs_n;
  logic vs_n;
  logic swap_now;

  // Raster region decode and the vertical-blank swap decision
  always_comb begin
    active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_n        = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_n        = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    frame_start = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
    swap_now    = frame_start && (pending_q || swap_req);
    swap_ack    = swap_now;
  end

  // Read request straight from the counters; read_en is held low while in reset
  // because the counters sit at the first active pixel there
  always_comb begin
    read_en  = active && rst_n;
    read_buf = read_buf_q;
`ifdef FRAME_SCANNER_SCALE2_EN
    read_x   = active ? (h_cnt_q >> 1) : '0;
    read_y   = active ? (v_cnt_q >> 1) : '0;
`else
    read_x   = active ? h_cnt_q : '0;
    read_y   = active ? v_cnt_q : '0;
`endif
  end

  // Next-state: counters, swap bookkeeping, alignment delay line and pixel map
  always_comb begin
    h_cnt_d    = h_cnt_q + 1'b1;
    v_cnt_d    = v_cnt_q;
    read_buf_d = read_buf_q;
    pending_d  = pending_q;

    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end

    // Honour a request in the frame_start cycle itself; repeats only re-set pending
    if (swap_now) begin
      read_buf_d = !read_buf_q;
      pending_d  = 1'b0;
    end else if (swap_req) begin
      pending_d  = 1'b1;
    end

    de_pipe_d[0] = active;
    hs_pipe_d[0] = hs_n;
    vs_pipe_d[0] = vs_n;
    for (int i = 1; i < READ_LATENCY; i++) begin
      de_pipe_d[i] = de_pipe_q[i-1];
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
    end

    video_de_d    = de_pipe_q[READ_LATENCY-1];
    video_hsync_d = hs_pipe_q[READ_LATENCY-1];
    video_vsync_d = vs_pipe_q[READ_LATENCY-1];
    video_rgb_d   = 24'h000000;
    if (de_pipe_q[READ_LATENCY-1]) begin
      case (read_palette)
        2'd0:    video_rgb_d = 24'hFFFFFF;
        2'd1:    video_rgb_d = 24'hACACAC;
        2'd2:    video_rgb_d = 24'h535353;
        default: video_rgb_d = 24'h000000;
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      read_buf_q    <= 1'b0;
      pending_q     <= 1'b0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      video_hsync_q <= 1'b1;
      video_vsync_q <= 1'b1;
      video_de_q    <= 1'b0;
      video_rgb_q   <= 24'h000000;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      read_buf_q    <= read_buf_d;
      pending_q     <= pending_d;
      de_pipe_q     <= de_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      video_hsync_q <= video_hsync_d;
      video_vsync_q <= video_vsync_d;
      video_de_q    <= video_de_d;
      video_rgb_q   <= video_rgb_d;
    end
  end

  assign video_hsync = video_hsync_q;
  assign video_vsync = video_vsync_q;
  assign video_de    = video_de_q;
  assign video_red   = video_rgb_q[23:16];
  assign video_green = video_rgb_q[15:8];
  assign video_blue  = video_rgb_q[7:0];

endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner with a shrunken raster so several frames fit in a
// short run. A framebuffer model answers reads after a fixed latency, and a
// cycle-index model derives every expected output from raster arithmetic.
module tb_frame_scanner;
  localparam int CW  = 12;
  localparam int HA  = 16, HF = 4, HS = 3, HB = 5;
  localparam int VA  = 10, VF = 2, VS = 2, VB = 3;
  localparam int LAT = 2;
  localparam int HT    = HA + HF + HS + HB;   // 28
  localparam int VT    = VA + VF + VS + VB;   // 17
  localparam int FRAME = HT * VT;             // 476
  localparam int FS_T  = VA * HT;             // cycle of frame_start within a frame
  localparam int VLAG  = LAT + 1;

  logic          clk_33m = 1'b0;
  logic          rst_n;
  logic          read_en;
  logic [CW-1:0] read_x, read_y;
  logic          read_buf;
  logic [1:0]    read_palette;
  logic          swap_req;
  logic          swap_ack, frame_start;
  logic          video_hsync, video_vsync, video_de;
  logic [7:0]    video_red, video_green, video_blue;

  frame_scanner #(
    .COOR_WIDTH(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .READ_LATENCY(LAT)
  ) dut (
    .clk_33m(clk_33m), .rst_n(rst_n), .read_en(read_en), .read_x(read_x),
    .read_y(read_y), .read_buf(read_buf), .read_palette(read_palette),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
    .video_hsync(video_hsync), .video_vsync(video_vsync), .video_de(video_de),
    .video_red(video_red), .video_green(video_green), .video_blue(video_blue)
  );

  always #5 clk_33m = ~clk_33m;

  // cycle index since the last reset release
  int t;
  always @(posedge clk_33m or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  int n_pass = 0;
  int n_checks = 0;
  bit done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
  endtask

  // framebuffer contents: x[1:0] on row 0 of buffer 0, varied by row parity and buffer
  function automatic logic [1:0] pal_of(int x, int y, bit b);
    return 2'((x ^ (y & 1) ^ (b ? 2 : 0)) & 3);
  endfunction

  function automatic logic [23:0] rgb_of(logic [1:0] p);
    case (p)
      2'd0:    return 24'hFFFFFF;
      2'd1:    return 24'hACACAC;
      2'd2:    return 24'h535353;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic int lx(int h);
`ifdef FRAME_SCANNER_SCALE2_EN
    return h / 2;
`else
    return h;
`endif
  endfunction

  // model state
  bit          m_buf, m_pend;
  bit          buf_hist [8];
  bit          req_en   [8];
  int          req_x    [8];
  int          req_y    [8];
  bit          req_b    [8];
  int          de_count, fs_count;
  logic [23:0] lit [4];

  initial begin
`ifdef FRAME_SCANNER_SCALE2_EN
    lit[0] = 24'hFFFFFF; lit[1] = 24'hFFFFFF; lit[2] = 24'hACACAC; lit[3] = 24'hACACAC;
`else
    lit[0] = 24'hFFFFFF; lit[1] = 24'hACACAC; lit[2] = 24'h535353; lit[3] = 24'h000000;
`endif
  end

  // Compare process: every cycle, on the falling edge
  always @(negedge clk_33m) begin : cmp
    int h, v, sh, sv, src;
    bit act, sact, fs, ack;
    logic [23:0] rgb, exp_rgb;
    if (!done) begin
      rgb = {video_red, video_green, video_blue};
      if (!rst_n) begin
        chk("rst_read_en", read_en, 0);
        chk("rst_read_x", read_x, 0);
        chk("rst_read_y", read_y, 0);
        chk("rst_read_buf", read_buf, 0);
        chk("rst_swap_ack", swap_ack, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_hsync", video_hsync, 1);
        chk("rst_vsync", video_vsync, 1);
        chk("rst_de", video_de, 0);
        chk("rst_rgb", rgb, 0);
        m_buf = 0; m_pend = 0; de_count = 0; fs_count = 0;
        read_palette = 2'($urandom);
      end else begin
        h = t % HT;
        v = (t / HT) % VT;
        act = (h < HA) && (v < VA);
        chk("read_en", read_en, act);
        chk("read_x", read_x, act ? lx(h) : 0);
        chk("read_y", read_y, act ? lx(v) : 0);
        chk("read_buf", read_buf, m_buf);
        fs  = (h == 0) && (v == VA);
        ack = fs && (m_pend || swap_req);
        chk("frame_start", frame_start, fs);
        chk("swap_ack", swap_ack, ack);
        buf_hist[t % 8] = m_buf;

        if (t < VLAG) begin
          chk("early_hsync", video_hsync, 1);
          chk("early_vsync", video_vsync, 1);
          chk("early_de", video_de, 0);
          chk("early_rgb", rgb, 0);
        end else begin
          src  = t - VLAG;
          sh   = src % HT;
          sv   = (src / HT) % VT;
          sact = (sh < HA) && (sv < VA);
          exp_rgb = sact ? rgb_of(pal_of(lx(sh), lx(sv), buf_hist[src % 8])) : 24'h0;
          chk("video_hsync", video_hsync, !(sh >= HA + HF && sh < HA + HF + HS));
          chk("video_vsync", video_vsync, !(sv >= VA + VF && sv < VA + VF + VS));
          chk("video_de", video_de, sact);
          chk("video_rgb", rgb, exp_rgb);
        end

        // hand-computed pins
        if (t == VLAG - 1) chk("de_before_rise", video_de, 0);
        if (t == VLAG)     chk("de_rise", video_de, 1);
        if (t >= VLAG && t < VLAG + 4) chk("pix_lit", rgb, lit[t - VLAG]);
        if (t == 22) chk("hsync_pre_lit", video_hsync, 1);
        if (t == 23) chk("hsync_first_low_lit", video_hsync, 0);
        if (t >= VLAG && t < VLAG + FRAME && video_de) de_count++;
        if (t == VLAG + FRAME) chk("de_per_frame", de_count, 160);
        if (t < FRAME && frame_start) fs_count++;
        if (t == FRAME) chk("fs_per_frame", fs_count, 1);

        // swap rules
        if (ack) begin
          m_buf  = !m_buf;
          m_pend = 0;
        end else if (swap_req) begin
          m_pend = 1;
        end

        // framebuffer answers the request made LAT cycles ago
        req_en[t % 8] = read_en;
        req_x[t % 8]  = int'(read_x);
        req_y[t % 8]  = int'(read_y);
        req_b[t % 8]  = read_buf;
        if (t >= LAT && req_en[(t - LAT) % 8])
          read_palette = pal_of(req_x[(t - LAT) % 8], req_y[(t - LAT) % 8], req_b[(t - LAT) % 8]);
        else
          read_palette = 2'($urandom);
      end
    end
  end

  task automatic wait_t(input int target);
    int guard;
    guard = 0;
    while (t < target && guard < 4 * FRAME) begin
      @(posedge clk_33m); #1;
      guard++;
    end
    if (t != target) chk("wait_timeout", t, target);
  endtask

  task automatic pulse_at(input int target);
    if (target >= t) begin
      wait_t(target);
      swap_req = 1'b1;
      @(posedge clk_33m); #1;
      swap_req = 1'b0;
    end
  endtask

  initial begin
    int seg;
    rst_n = 1'b0;
    swap_req = 1'b0;
    read_palette = 2'd0;
    repeat (3) @(posedge clk_33m);
    #1 rst_n = 1'b1;

    // frame 0: one request mid-frame, honoured at frame_start only
    pulse_at(5 * HT + 7);
    wait_t(FS_T - 1);
    chk("buf_before_swap0", read_buf, 0);
    wait_t(FS_T + 1);
    chk("buf_after_swap0", read_buf, 1);

    // frame 1: two requests, single toggle
    pulse_at(FRAME + 2 * HT + 3);
    pulse_at(FRAME + 6 * HT + 9);
    wait_t(FRAME + FS_T + 1);
    chk("buf_after_swap1", read_buf, 0);

    // frame 2: request exactly in the frame_start cycle
    pulse_at(2 * FRAME + FS_T);
    chk("buf_after_swap2", read_buf, 1);

    // randomized frames
    seg = FRAME / 4;
    for (int f = 3; f < 10; f++) begin
      if ($urandom_range(0, 1) == 1) pulse_at(f * FRAME + $urandom_range(1, seg - 2));
      if ($urandom_range(0, 1) == 1) pulse_at(f * FRAME + seg + $urandom_range(0, seg - 2));
      if ($urandom_range(0, 2) == 0) pulse_at(f * FRAME + FS_T);
      if ($urandom_range(0, 1) == 1) pulse_at(f * FRAME + 3 * seg + $urandom_range(0, seg - 2));
    end

    // mid-frame reset with a swap pending: pending must be lost
    pulse_at(10 * FRAME + 2 * HT);
    wait_t(10 * FRAME + 6 * HT + 12);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_33m);
    #1 rst_n = 1'b1;
    wait_t(FS_T + 1);
    chk("buf_pending_lost", read_buf, 0);
    wait_t(FRAME + 10);
    pulse_at(FRAME + HT * 3);
    wait_t(2 * FRAME + 10);

    @(negedge clk_33m);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
